// File: rtl/mure_pkg.sv
// Shared types and constants for the multiple-retirement trace path.
// te_block_s is one retirement block descriptor; it is the unit held by the
// merger accumulator and by its output queue.
package mure_pkg;

  localparam int XLEN        = 32;
  localparam int IRETIRE_LEN = 7;
  localparam int ITYPE_LEN   = 4;
  localparam int CAUSE_LEN   = 5;
  localparam int PRIV_LEN    = 2;

  localparam int MERGE_TIMEOUT_DEFAULT = 64;
  localparam int MERGE_QDEPTH          = 2;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        iaddr;
  } te_block_s;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } merge_state_e;

  // Address of the first half-word after the block (wraps mod 2^XLEN).
  function automatic logic [XLEN-1:0] blk_next_addr(input te_block_s b);
    return b.iaddr + {{(XLEN-IRETIRE_LEN-1){1'b0}}, b.iretire, 1'b0};
  endfunction

endpackage

// File: rtl/te_block_queue.sv
// Two-entry FIFO of te_block_s with two ordered push ports and one pop port.
// Entry 0 is always the head, so the head data comes straight from a register.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_push0 / i_data0    first entry written this cycle
//   i_push1 / i_data1    second entry, only together with i_push0
//   i_pop                consumer took the head this cycle
//   o_valid / o_head     head entry present / head contents
//   o_count              number of occupied entries (0..2)
// The writer guarantees that pushes never exceed the free space after the pop.
module te_block_queue
  import mure_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push0,
  input  te_block_s i_data0,
  input  logic      i_push1,
  input  te_block_s i_data1,
  input  logic      i_pop,
  output logic      o_valid,
  output te_block_s o_head,
  output logic [1:0] o_count
);

  te_block_s  r_ent0, r_ent1;
  logic [1:0] r_count;

  te_block_s  w_nxt0, w_nxt1;
  logic [1:0] w_cnt_after_pop, w_nxt_count;
  logic       w_pop;

  always_comb begin
    w_pop           = i_pop && (r_count != 2'd0);
    w_nxt0          = r_ent0;
    w_nxt1          = r_ent1;
    w_cnt_after_pop = r_count;
    if (w_pop) begin
      w_nxt0          = r_ent1;
      w_cnt_after_pop = r_count - 2'd1;
    end
    w_nxt_count = w_cnt_after_pop;
    if (i_push0) begin
      if (w_cnt_after_pop == 2'd0) w_nxt0 = i_data0;
      else                         w_nxt1 = i_data0;
      w_nxt_count = w_cnt_after_pop + 2'd1;
    end
    // A second push only fits when the queue is empty after the pop,
    // so it always lands in entry 1 behind i_data0.
    if (i_push1) begin
      w_nxt1      = i_data1;
      w_nxt_count = w_cnt_after_pop + 2'd2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_count <= 2'd0;
    end else begin
      r_ent0  <= w_nxt0;
      r_ent1  <= w_nxt1;
      r_count <= w_nxt_count;
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_head  = r_ent0;
  assign o_count = r_count;

endmodule

// File: rtl/te_block_merger.sv
// Merges consecutive contiguous itype=0 retirement blocks into a single block
// before they reach the trace encoder, and buffers results in a 2-entry
// valid/ready queue. The input has no back-pressure: a beat that cannot be
// queued is dropped whole and reported on overflow_o.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   valid_i + block fields   incoming block descriptor
//   flush_i                  close and emit the open accumulator
//   ready_i                  encoder accepts the output descriptor
//   valid_o + block fields   output descriptor (queue head)
//   overflow_o               one-cycle pulse after an input beat was dropped
// Parameter TIMEOUT: idle cycles in ACCUM before a forced flush (0 = never).
module te_block_merger
  import mure_pkg::*;
#(
  parameter int TIMEOUT = MERGE_TIMEOUT_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  input  logic [IRETIRE_LEN-1:0] iretire_i,
  input  logic                   ilastsize_i,
  input  logic [ITYPE_LEN-1:0]   itype_i,
  input  logic [CAUSE_LEN-1:0]   cause_i,
  input  logic [XLEN-1:0]        tval_i,
  input  logic [PRIV_LEN-1:0]    priv_i,
  input  logic [XLEN-1:0]        iaddr_i,
  input  logic                   flush_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [IRETIRE_LEN-1:0] iretire_o,
  output logic                   ilastsize_o,
  output logic [ITYPE_LEN-1:0]   itype_o,
  output logic [CAUSE_LEN-1:0]   cause_o,
  output logic [XLEN-1:0]        tval_o,
  output logic [PRIV_LEN-1:0]    priv_o,
  output logic [XLEN-1:0]        iaddr_o,
  output logic                   overflow_o
);

  localparam int QDEPTH     = MERGE_QDEPTH;
  localparam int TMO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LAST_I);

  merge_state_e     r_state, w_state_nxt;
  te_block_s        r_acc, w_acc_nxt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_overflow;

  te_block_s            w_in, w_merged, w_in_blk, w_enq0, w_enq1, w_q_head;
  logic [IRETIRE_LEN:0] w_sum;
  logic                 w_accum, w_contig, w_break, w_expire, w_emit_acc;
  logic                 w_can_merge, w_term, w_pop, w_fits, w_drop;
  logic                 w_push0, w_push1, w_q_valid;
  logic [1:0]           w_need, w_free, w_q_count;

  assign w_in = '{iretire: iretire_i, ilastsize: ilastsize_i, itype: itype_i,
                  cause: cause_i, tval: tval_i, priv: priv_i, iaddr: iaddr_i};

  // One extra bit on the sum so an oversize merge is visible as a carry.
  assign w_sum    = {1'b0, r_acc.iretire} + {1'b0, iretire_i};
  assign w_accum  = (r_state == ST_ACCUM);
  assign w_contig = (iaddr_i == blk_next_addr(r_acc));
  assign w_break  = w_accum && valid_i &&
                    (!w_contig || (priv_i != r_acc.priv) || w_sum[IRETIRE_LEN]);
  assign w_expire = (TIMEOUT != 0) && w_accum && !valid_i && (r_tmo_cnt == TMO_LAST);

  // Once the accumulator is emitted the input is handled as if we were IDLE.
  assign w_emit_acc  = w_accum && (flush_i || w_break || w_expire);
  assign w_can_merge = w_accum && !w_emit_acc;
  assign w_term      = valid_i && (itype_i != '0);

  assign w_merged = '{iretire: w_sum[IRETIRE_LEN-1:0], ilastsize: ilastsize_i,
                      itype: itype_i, cause: cause_i, tval: tval_i, priv: priv_i,
                      iaddr: r_acc.iaddr};
  assign w_in_blk = w_can_merge ? w_merged : w_in;

  // Slot accounting: the head leaving this cycle frees a slot for a push.
  assign w_pop  = w_q_valid && ready_i;
  assign w_need = {1'b0, w_emit_acc} + {1'b0, w_term};
  assign w_free = 2'(QDEPTH) - w_q_count + {1'b0, w_pop};
  assign w_fits = (w_need <= w_free);
  assign w_drop = valid_i && !w_fits;

  // The accumulator entry always goes ahead of the input-derived entry.
  assign w_push0 = w_fits && (w_emit_acc || w_term);
  assign w_push1 = w_fits && w_emit_acc && w_term;
  assign w_enq0  = w_emit_acc ? r_acc : w_in_blk;
  assign w_enq1  = w_in_blk;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    if (w_fits) begin
      if (w_emit_acc) w_state_nxt = ST_IDLE;
      if (valid_i) begin
        if (itype_i != '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACCUM;
          w_acc_nxt   = w_in_blk;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_tmo_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_overflow <= w_drop;
      // Saturating at the last value keeps a blocked expiry retrying.
      if (valid_i || (w_state_nxt == ST_IDLE)) r_tmo_cnt <= '0;
      else if (w_accum && (r_tmo_cnt != TMO_LAST)) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  te_block_queue u_queue (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push0 (w_push0),
    .i_data0 (w_enq0),
    .i_push1 (w_push1),
    .i_data1 (w_enq1),
    .i_pop   (ready_i),
    .o_valid (w_q_valid),
    .o_head  (w_q_head),
    .o_count (w_q_count)
  );

  assign valid_o     = w_q_valid;
  assign iretire_o   = w_q_head.iretire;
  assign ilastsize_o = w_q_head.ilastsize;
  assign itype_o     = w_q_head.itype;
  assign cause_o     = w_q_head.cause;
  assign tval_o      = w_q_head.tval;
  assign priv_o      = w_q_head.priv;
  assign iaddr_o     = w_q_head.iaddr;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_te_block_merger.sv
`timescale 1ns/1ps
module tb_te_block_merger;
  import mure_pkg::*;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   valid_i = 1'b0;
  logic [IRETIRE_LEN-1:0] iretire_i = '0;
  logic                   ilastsize_i = 1'b0;
  logic [ITYPE_LEN-1:0]   itype_i = '0;
  logic [CAUSE_LEN-1:0]   cause_i = '0;
  logic [XLEN-1:0]        tval_i = '0;
  logic [PRIV_LEN-1:0]    priv_i = '0;
  logic [XLEN-1:0]        iaddr_i = '0;
  logic                   flush_i = 1'b0;
  logic                   ready_i = 1'b1;
  logic                   valid_o;
  logic [IRETIRE_LEN-1:0] iretire_o;
  logic                   ilastsize_o;
  logic [ITYPE_LEN-1:0]   itype_o;
  logic [CAUSE_LEN-1:0]   cause_o;
  logic [XLEN-1:0]        tval_o;
  logic [PRIV_LEN-1:0]    priv_o;
  logic [XLEN-1:0]        iaddr_o;
  logic                   overflow_o;

  always #5 clk_i = ~clk_i;

  te_block_merger #(.TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .iretire_i(iretire_i),
    .ilastsize_i(ilastsize_i), .itype_i(itype_i), .cause_i(cause_i), .tval_i(tval_i),
    .priv_i(priv_i), .iaddr_i(iaddr_i), .flush_i(flush_i), .ready_i(ready_i),
    .valid_o(valid_o), .iretire_o(iretire_o), .ilastsize_o(ilastsize_o),
    .itype_o(itype_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
    .iaddr_o(iaddr_o), .overflow_o(overflow_o)
  );

  int        n_vec = 0;
  int        n_err = 0;
  te_block_s got_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every accepted output descriptor, in handshake order.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && ready_i)
      got_q.push_back(te_block_s'{iretire: iretire_o, ilastsize: ilastsize_o,
                                  itype: itype_o, cause: cause_o, tval: tval_o,
                                  priv: priv_o, iaddr: iaddr_o});
  end

  task automatic send(input logic [6:0] iret, input logic ils, input logic [3:0] ityp,
                      input logic [4:0] cs, input logic [31:0] tv, input logic [1:0] pv,
                      input logic [31:0] addr);
    @(posedge clk_i); #2;
    valid_i = 1'b1; iretire_i = iret; ilastsize_i = ils; itype_i = ityp;
    cause_i = cs; tval_i = tv; priv_i = pv; iaddr_i = addr; flush_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #2;
      valid_i = 1'b0; flush_i = 1'b0;
    end
  endtask

  task automatic pulse_flush();
    @(posedge clk_i); #2;
    valid_i = 1'b0; flush_i = 1'b1;
    idle(1);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] addr, input logic [6:0] iret,
                            input logic ils, input logic [3:0] ityp, input logic [4:0] cs,
                            input logic [31:0] tv, input logic [1:0] pv);
    te_block_s g;
    int        w;
    w = 0;
    while (got_q.size() == 0 && w < 40) begin
      @(negedge clk_i);
      w++;
    end
    check({tag, "_present"}, (got_q.size() != 0), 1'b1);
    if (got_q.size() != 0) begin
      g = got_q.pop_front();
      check({tag, "_iaddr"}, g.iaddr, addr);
      check({tag, "_iretire"}, g.iretire, iret);
      check({tag, "_itype"}, g.itype, ityp);
      check({tag, "_misc"}, {g.ilastsize, g.cause, g.tval, g.priv}, {ils, cs, tv, pv});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_overflow_o", overflow_o, 1'b0);
    check("rst_data", {iaddr_o, iretire_o, itype_o, tval_o}, '0);
    @(posedge clk_i); #2; rst_ni = 1'b1;
    idle(2);
    @(negedge clk_i);
    check("post_rst_valid_o", valid_o, 1'b0);

    // Three contiguous beats merged with a terminating fourth
    send(7'd4, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3, 32'h1000);
    send(7'd2, 1'b1, 4'd0, 5'd0, 32'h0, 2'd3, 32'h1008);
    send(7'd3, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3, 32'h100C);
    send(7'd1, 1'b1, 4'd4, 5'd5, 32'hDEAD, 2'd3, 32'h1012);
    idle(1);
    expect_out("merge4", 32'h1000, 7'd10, 1'b1, 4'd4, 5'd5, 32'hDEAD, 2'd3);
    idle(4);
    check("merge4_single", got_q.size(), 0);

    // Address discontinuity; the new accumulator is 0x3000
    send(7'd2, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3, 32'h2000);
    send(7'd5, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3, 32'h3000);
    send(7'd1, 1'b1, 4'd2, 5'd0, 32'h0, 2'd3, 32'h300A);
    idle(1);
    expect_out("brk_acc", 32'h2000, 7'd2, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3);
    expect_out("brk_new", 32'h3000, 7'd6, 1'b1, 4'd2, 5'd0, 32'h0, 2'd3);

    // Privilege change on a contiguous address: acc and input both emitted
    send(7'd2, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3, 32'h4000);
    send(7'd1, 1'b1, 4'd1, 5'd0, 32'h0, 2'd0, 32'h4004);
    idle(1);
    expect_out("priv_a", 32'h4000, 7'd2, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3);
    expect_out("priv_b", 32'h4004, 7'd1, 1'b1, 4'd1, 5'd0, 32'h0, 2'd0);

    // iretire sum of 128 does not fit in 7 bits
    send(7'd126, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3, 32'h5000);
    send(7'd2, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3, 32'h50FC);
    pulse_flush();
    expect_out("ovf_acc", 32'h5000, 7'd126, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3);
    expect_out("ovf_new", 32'h50FC, 7'd2, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3);

    // Contiguity wraps around the top of the address space
    send(7'd2, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3, 32'hFFFF_FFFC);
    send(7'd1, 1'b0, 4'd2, 5'd0, 32'h0, 2'd3, 32'h0000_0000);
    idle(1);
    expect_out("wrap", 32'hFFFF_FFFC, 7'd3, 1'b0, 4'd2, 5'd0, 32'h0, 2'd3);

    // flush_i with an empty accumulator
    pulse_flush();
    idle(4);
    @(negedge clk_i);
    check("flush_idle_none", got_q.size(), 0);
    check("flush_idle_valid", valid_o, 1'b0);

    // Back-pressure: two beats queue, third is dropped
    send(7'd1, 1'b0, 4'd2, 5'd0, 32'h0, 2'd3, 32'h6000);
    ready_i = 1'b0;
    send(7'd1, 1'b0, 4'd2, 5'd0, 32'h0, 2'd3, 32'h6100);
    send(7'd1, 1'b0, 4'd2, 5'd0, 32'h0, 2'd3, 32'h6200);
    idle(1);
    @(negedge clk_i);
    check("bp_overflow_pulse", overflow_o, 1'b1);
    check("bp_head_valid", valid_o, 1'b1);
    check("bp_head_stable", iaddr_o, 32'h6000);
    check("bp_none_taken", got_q.size(), 0);
    idle(1);
    ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_overflow_end", overflow_o, 1'b0);
    expect_out("bp_q0", 32'h6000, 7'd1, 1'b0, 4'd2, 5'd0, 32'h0, 2'd3);
    expect_out("bp_q1", 32'h6100, 7'd1, 1'b0, 4'd2, 5'd0, 32'h0, 2'd3);
    idle(4);
    check("bp_third_dropped", got_q.size(), 0);

    // Timeout flush of a lone accumulator
    send(7'd3, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3, 32'h7000);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      idle(1);
      @(negedge clk_i);
      if (valid_o) begin
        lat = i - 1;
        break;
      end
    end
    check("tmo_latency", lat, 8);
    expect_out("tmo_out", 32'h7000, 7'd3, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3);

    // Timeout expiry blocked by a full queue, retried once ready_i rises
    send(7'd1, 1'b0, 4'd2, 5'd0, 32'h0, 2'd3, 32'h8000);
    ready_i = 1'b0;
    send(7'd1, 1'b0, 4'd2, 5'd0, 32'h0, 2'd3, 32'h8100);
    send(7'd3, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3, 32'h8200);
    idle(14);
    @(negedge clk_i);
    check("tmo_blk_head", iaddr_o, 32'h8000);
    check("tmo_blk_none", got_q.size(), 0);
    @(posedge clk_i); #2; ready_i = 1'b1;
    expect_out("tmo_blk_q0", 32'h8000, 7'd1, 1'b0, 4'd2, 5'd0, 32'h0, 2'd3);
    expect_out("tmo_blk_q1", 32'h8100, 7'd1, 1'b0, 4'd2, 5'd0, 32'h0, 2'd3);
    expect_out("tmo_blk_acc", 32'h8200, 7'd3, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3);

    // Reset while the queue and accumulator are occupied
    ready_i = 1'b0;
    send(7'd1, 1'b0, 4'd2, 5'd0, 32'h0, 2'd3, 32'h9000);
    send(7'd2, 1'b0, 4'd0, 5'd0, 32'h0, 2'd3, 32'h9100);
    idle(1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("midrst_valid_o", valid_o, 1'b0);
    check("midrst_iaddr_o", iaddr_o, 32'h0);
    @(posedge clk_i); #2; rst_ni = 1'b1; ready_i = 1'b1;
    idle(14);
    check("midrst_no_emit", got_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
